// File: rtl/alu_multicycle.sv
// alu_multicycle: registered WIDTH-bit ALU with start/busy/done handshake,
// single-cycle logic/arith ops plus shift-add MUL and restoring DIV.
module alu_multicycle #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             P,
    output logic             Z,
    output logic             S,
    output logic             C,
    output logic             OV
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    localparam logic [3:0] OP_MUL = 4'd12;
    localparam logic [3:0] OP_DIV = 4'd13;
    localparam int CW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               cin_q, cin_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]   out_q, out_d, hi_q, hi_d;
    logic               p_q, p_d, z_q, z_d, s_q, s_d, c_q, c_d, ov_q, ov_d;

    logic [WIDTH-1:0]   res, res_hi;
    logic               res_c, res_ov;
    logic [WIDTH:0]     mul_sum, div_tmp, div_diff;

    // acc holds {hi, lo}: MUL {partial product, multiplier}, DIV {remainder, dividend/quotient}
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_tmp - {1'b0, b_q};
    end

    always_comb begin
        res    = '0;
        res_hi = '0;
        res_c  = 1'b0;
        res_ov = 1'b0;
        case (op_q)
            4'd0: res = b_q;
            4'd1: res = a_q & b_q;
            4'd2: res = a_q | b_q;
            4'd3: res = a_q ^ b_q;
            4'd4: begin
                {res_c, res} = {1'b0, a_q} + {1'b0, b_q};
                res_ov = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd5: begin
                {res_c, res} = {1'b0, a_q} - {1'b0, b_q};
                res_ov = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd6: begin
                {res_c, res} = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
                res_ov = ~a_q[WIDTH-1] & res[WIDTH-1];
            end
            4'd7: res = ~a_q;
            4'd8: begin
                {res_c, res} = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
                res_ov = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd9: begin
                {res_c, res} = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_q};
                res_ov = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd10: {res_c, res} = {a_q, 1'b0};
            4'd11: {res, res_c} = {1'b0, a_q};
            OP_MUL: begin
                {res_hi, res} = acc_q;
                res_c = |acc_q[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                res    = (b_q == '0) ? '1 : acc_q[WIDTH-1:0];
                res_hi = (b_q == '0) ? a_q : acc_q[2*WIDTH-1:WIDTH];
                res_ov = (b_q == '0);
            end
            default: res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        hi_d    = hi_q;
        p_d     = p_q;
        z_d     = z_q;
        s_d     = s_q;
        c_d     = c_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: if (start) begin
                op_d    = alu_op;
                a_d     = a;
                b_d     = b;
                cin_d   = c_in;
                acc_d   = {{WIDTH{1'b0}}, a};
                cnt_d   = CW'(WIDTH - 1);
                busy_d  = 1'b1;
                state_d = (alu_op == OP_MUL || (alu_op == OP_DIV && b != '0)) ? CALC : FIN;
            end
            CALC: begin
                acc_d = (op_q == OP_DIV)
                      ? {(div_diff[WIDTH] ? div_tmp[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], ~div_diff[WIDTH]}
                      : {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? FIN : CALC;
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                out_d   = res;
                hi_d    = res_hi;
                p_d     = ~^res;
                z_d     = (res == '0);
                s_d     = res[WIDTH-1];
                c_d     = res_c;
                ov_d    = res_ov;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            hi_q    <= '0;
            p_q     <= 1'b0;
            z_q     <= 1'b0;
            s_q     <= 1'b0;
            c_q     <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            hi_q    <= hi_d;
            p_q     <= p_d;
            z_q     <= z_d;
            s_q     <= s_d;
            c_q     <= c_d;
            ov_q    <= ov_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign out    = out_q;
    assign out_hi = hi_q;
    assign P      = p_q;
    assign Z      = z_q;
    assign S      = s_q;
    assign C      = c_q;
    assign OV     = ov_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed vectors for alu_multicycle (WIDTH=8) with
// hand-computed results, latency, handshake, busy-ignore and async reset abort.
module tb_alu_multicycle;
    logic       clk = 1'b0;
    logic       rst_n, start, c_in;
    logic [3:0] alu_op;
    logic [7:0] a, b, out, out_hi;
    logic       busy, done, P, Z, S, C, OV;
    int         n_vec = 0;
    int         n_err = 0;

    alu_multicycle #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .a(a), .b(b),
        .c_in(c_in), .busy(busy), .done(done), .out(out), .out_hi(out_hi),
        .P(P), .Z(Z), .S(S), .C(C), .OV(OV)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb,
                       input logic ci, output int lat);
        @(negedge clk);
        start = 1'b1; alu_op = op; a = va; b = vb; c_in = ci;
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("op%0d busy after accept", op), busy, 1);
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done) lat = k;
        end
    endtask

    task automatic vec(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb,
                       input logic ci, input logic [7:0] eo, input logic [7:0] eh,
                       input logic ec, input logic eov, input int elat);
        int    lat;
        string t;
        t = $sformatf("op%0d a=%h b=%h", op, va, vb);
        run(op, va, vb, ci, lat);
        check({t, " latency"}, lat, elat);
        check({t, " out"}, out, eo);
        check({t, " out_hi"}, out_hi, eh);
        check({t, " C"}, C, ec);
        check({t, " OV"}, OV, eov);
        check({t, " P"}, P, ~^eo);
        check({t, " Z"}, Z, eo == 8'h00);
        check({t, " S"}, S, eo[7]);
        check({t, " busy at done"}, busy, 0);
        @(posedge clk); #1;
        check({t, " done pulse"}, done, 0);
    endtask

    initial begin
        int ndone, dedge;
        rst_n = 1'b0; start = 1'b0; alu_op = '0; a = '0; b = '0; c_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset out", out, 0);
        check("reset out_hi", out_hi, 0);
        check("reset flags", {P, Z, S, C, OV}, 5'b0);

        //  op     a      b      ci    out    hi     C     OV    lat
        vec(4'd4,  8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1);
        vec(4'd5,  8'h80, 8'h01, 1'b0, 8'h7F, 8'h00, 1'b0, 1'b1, 1);
        vec(4'd5,  8'h01, 8'h02, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 1);
        vec(4'd12, 8'hC8, 8'h03, 1'b0, 8'h58, 8'h02, 1'b1, 1'b0, 9);
        vec(4'd13, 8'h64, 8'h07, 1'b0, 8'h0E, 8'h02, 1'b0, 1'b0, 9);
        vec(4'd13, 8'h55, 8'h00, 1'b0, 8'hFF, 8'h55, 1'b0, 1'b1, 1);
        vec(4'd0,  8'h12, 8'h34, 1'b0, 8'h34, 8'h00, 1'b0, 1'b0, 1);
        vec(4'd1,  8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 1);
        vec(4'd2,  8'hF0, 8'h3C, 1'b0, 8'hFC, 8'h00, 1'b0, 1'b0, 1);
        vec(4'd3,  8'hF0, 8'h3C, 1'b0, 8'hCC, 8'h00, 1'b0, 1'b0, 1);
        vec(4'd4,  8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1);
        vec(4'd6,  8'h7F, 8'h00, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1);
        vec(4'd6,  8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1);
        vec(4'd7,  8'h5A, 8'h00, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1);
        vec(4'd8,  8'h7F, 8'h00, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1, 1);
        vec(4'd8,  8'hFF, 8'hFF, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1);
        vec(4'd9,  8'h00, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1);
        vec(4'd9,  8'h10, 8'h05, 1'b1, 8'h0A, 8'h00, 1'b0, 1'b0, 1);
        vec(4'd10, 8'h81, 8'h00, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 1);
        vec(4'd11, 8'h81, 8'h00, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 1);
        vec(4'd15, 8'hFF, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1);
        vec(4'd12, 8'h00, 8'h37, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 9);
        vec(4'd13, 8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 9);
        vec(4'd13, 8'h05, 8'h09, 1'b0, 8'h00, 8'h05, 1'b0, 1'b0, 9);
        vec(4'd12, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b1, 1'b0, 9);

        // MUL with an ADD request and operand changes while busy
        @(negedge clk);
        start = 1'b1; alu_op = 4'd12; a = 8'hC8; b = 8'h03;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; alu_op = 4'd4; a = 8'h01; b = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignored start busy", busy, 1);
        check("out held during calc", out, 8'h01);
        ndone = 0; dedge = 0;
        for (int k = 4; k <= 14; k++) begin
            @(posedge clk); #1;
            if (done) begin ndone++; dedge = k; end
        end
        check("busy-start done count", ndone, 1);
        check("busy-start done edge", dedge, 9);
        check("busy-start out", out, 8'h58);
        check("busy-start out_hi", out_hi, 8'h02);

        // async reset in the middle of a MUL
        @(negedge clk);
        start = 1'b1; alu_op = 4'd12; a = 8'h0F; b = 8'h0F;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort out", out, 0);
        check("abort out_hi", out_hi, 0);
        check("abort flags", {P, Z, S, C, OV}, 5'b0);
        ndone = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("abort no done", ndone, 0);
        vec(4'd4, 8'h03, 8'h04, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
